// File: rtl/l2_to_l3_batch_fifo.sv
// -----------------------------------------------------------------------------
// l2_to_l3_batch_fifo
//
// Pixel buffer between the conv layer 2 output and the conv2d_layer3 input.
// Stores 16-channel int8 pixels in a circular buffer and serves them to L3
// on rd_en, with the pixel appearing one cycle later on out_valid/out_data.
// It also produces the batch-level status L3 schedules its reads from, and
// it tracks a single frame at a time: once every pixel of a frame has been
// written, further writes are held off until the whole frame has been read.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   wr_valid/wr_data  pixel write from L2 (channel c at [8c+7:8c])
//   wr_ready          write is accepted this cycle when high
//   rd_en             read request from L3
//   out_valid         one pulse per returned pixel
//   out_data          returned pixel, same packing as wr_data
//   fifo_empty        no stored pixels
//   fifo_batch_ready  a full batch, or the frame tail, is readable
//   fifo_last_batch   the batch being read is the frame's final batch
//   frame_done        one-cycle pulse alongside the frame's last out_valid
//   overflow_err      sticky: write attempted while wr_ready was low
//   underflow_err     sticky: read attempted while empty
// -----------------------------------------------------------------------------
module l2_to_l3_batch_fifo #(
    parameter int IMG_W        = 14,
    parameter int IMG_H        = 14,
    parameter int CH           = 16,
    parameter int BATCH_SIZE   = 28,
    parameter int DEPTH        = 64,
    parameter int TOTAL_PIXELS = IMG_W * IMG_H
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_valid,
    input  logic [8*CH-1:0] wr_data,
    output logic            wr_ready,
    input  logic            rd_en,
    output logic            out_valid,
    output logic [8*CH-1:0] out_data,
    output logic            fifo_empty,
    output logic            fifo_batch_ready,
    output logic            fifo_last_batch,
    output logic            frame_done,
    output logic            overflow_err,
    output logic            underflow_err
);

    localparam int PW  = 8 * CH;
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int PCW = $clog2(TOTAL_PIXELS + 1);

    localparam logic [AW-1:0]  LAST_ADDR  = AW'(DEPTH - 1);
    localparam logic [CW-1:0]  DEPTH_C    = CW'(DEPTH);
    localparam logic [CW-1:0]  BATCH_C    = CW'(BATCH_SIZE);
    localparam logic [PCW-1:0] TOTAL_C    = PCW'(TOTAL_PIXELS);
    localparam logic [PCW-1:0] BATCH_P    = PCW'(BATCH_SIZE);

    logic [PW-1:0]  mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [PCW-1:0] wr_pix_cnt;
    logic [PCW-1:0] rd_pix_cnt;

    logic           frame_wr_done;
    logic           wr_acc;
    logic           rd_acc;
    logic           last_read;
    logic [CW-1:0]  count_nxt;
    logic [PCW-1:0] wr_pix_nxt;
    logic [PCW-1:0] rd_pix_nxt;
    logic           frame_wr_done_nxt;

    // wr_ready looks only at the pre-read count, so a full buffer refuses a
    // write even when a read frees a slot in the same cycle.
    assign frame_wr_done = (wr_pix_cnt == TOTAL_C);
    assign wr_ready      = (count < DEPTH_C) && !frame_wr_done;
    assign wr_acc        = wr_valid && wr_ready;
    assign rd_acc        = rd_en && !fifo_empty;
    // The final read of a frame; a write cannot coincide with it because the
    // frame's writes are already complete at that point.
    assign last_read     = rd_acc && (rd_pix_cnt == TOTAL_C - 1'b1);

    // Next values of the occupancy and frame counters. The status outputs are
    // registered from these so they agree with the counters after the update.
    always_comb begin
        count_nxt  = count;
        wr_pix_nxt = wr_pix_cnt + PCW'(wr_acc);
        rd_pix_nxt = rd_pix_cnt + PCW'(rd_acc);
        if (wr_acc && !rd_acc) begin
            count_nxt = count + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            count_nxt = count - 1'b1;
        end
        if (last_read) begin
            wr_pix_nxt = '0;
            rd_pix_nxt = '0;
        end
        frame_wr_done_nxt = (wr_pix_nxt == TOTAL_C);
    end

    // NOTE: the pixel storage has no reset; stale contents are unreachable
    // because the pointers and count are cleared, and leaving it unreset lets
    // it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: all state updates use non-blocking assignment so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            wr_pix_cnt       <= '0;
            rd_pix_cnt       <= '0;
            out_valid        <= 1'b0;
            out_data         <= '0;
            fifo_empty       <= 1'b1;
            fifo_batch_ready <= 1'b0;
            fifo_last_batch  <= 1'b0;
            frame_done       <= 1'b0;
            overflow_err     <= 1'b0;
            underflow_err    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr   <= (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + 1'b1;
                out_data <= mem[rd_ptr];
            end
            out_valid  <= rd_acc;
            frame_done <= last_read;

            count      <= count_nxt;
            wr_pix_cnt <= wr_pix_nxt;
            rd_pix_cnt <= rd_pix_nxt;

            fifo_empty       <= (count_nxt == '0);
            fifo_batch_ready <= (count_nxt >= BATCH_C) ||
                                (frame_wr_done_nxt && (count_nxt != '0));
            fifo_last_batch  <= frame_wr_done_nxt &&
                                ((TOTAL_C - rd_pix_nxt) <= BATCH_P) &&
                                (rd_pix_nxt < TOTAL_C);

            if (wr_valid && !wr_ready) begin
                overflow_err <= 1'b1;
            end
            if (rd_en && fifo_empty) begin
                underflow_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_l2_to_l3_batch_fifo.sv
// -----------------------------------------------------------------------------
// tb_l2_to_l3_batch_fifo
//
// Self-checking bench for l2_to_l3_batch_fifo. A queue-based model tracks the
// stored pixels, frame counters and sticky flags; a negedge process compares
// every DUT output with it each cycle. Directed phases add literal checks for
// reset, the batch threshold, read latency, overflow and underflow, and a
// randomized two-frame stream exercises L3-style batch reads.
// -----------------------------------------------------------------------------
module tb_l2_to_l3_batch_fifo;

    localparam int CH    = 16;
    localparam int PW    = 8 * CH;
    localparam int DEPTH = 64;
    localparam int BATCH = 28;
    localparam int TOTAL = 196;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_valid;
    logic [PW-1:0] wr_data;
    logic          wr_ready;
    logic          rd_en;
    logic          out_valid;
    logic [PW-1:0] out_data;
    logic          fifo_empty;
    logic          fifo_batch_ready;
    logic          fifo_last_batch;
    logic          frame_done;
    logic          overflow_err;
    logic          underflow_err;

    l2_to_l3_batch_fifo dut (
        .clk              (clk),
        .rst              (rst),
        .wr_valid         (wr_valid),
        .wr_data          (wr_data),
        .wr_ready         (wr_ready),
        .rd_en            (rd_en),
        .out_valid        (out_valid),
        .out_data         (out_data),
        .fifo_empty       (fifo_empty),
        .fifo_batch_ready (fifo_batch_ready),
        .fifo_last_batch  (fifo_last_batch),
        .frame_done       (frame_done),
        .overflow_err     (overflow_err),
        .underflow_err    (underflow_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    task automatic check(input string name, input logic [PW-1:0] got,
                         input logic [PW-1:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Pixel idx carries channel k = idx*(k+1) mod 256.
    function automatic logic [PW-1:0] pix(input int idx);
        logic [PW-1:0] d;
        for (int k = 0; k < CH; k++) begin
            d[8*k +: 8] = 8'((idx * (k + 1)) % 256);
        end
        return d;
    endfunction

    // ---------------- behavioural model ----------------
    logic [PW-1:0] q[$];
    int            m_wr;
    int            m_rd;
    bit            m_valid;
    bit            m_fd;
    bit            m_ovf;
    bit            m_unf;
    logic [PW-1:0] m_data;

    function automatic bit m_wr_ready();
        return (q.size() < DEPTH) && (m_wr != TOTAL);
    endfunction
    function automatic bit m_empty();
        return q.size() == 0;
    endfunction
    function automatic bit m_batch();
        return (q.size() >= BATCH) || ((m_wr == TOTAL) && (q.size() > 0));
    endfunction
    function automatic bit m_last();
        return (m_wr == TOTAL) && (TOTAL - m_rd <= BATCH) && (m_rd < TOTAL);
    endfunction

    task automatic model_step(input bit r, input bit we, input bit re,
                              input logic [PW-1:0] d);
        bit wr_ok;
        bit rd_ok;
        if (r) begin
            q.delete();
            m_wr = 0; m_rd = 0;
            m_valid = 0; m_fd = 0; m_ovf = 0; m_unf = 0;
            m_data = '0;
        end else begin
            wr_ok = we && m_wr_ready();
            rd_ok = re && !m_empty();
            if (we && !wr_ok) m_ovf = 1;
            if (re && m_empty()) m_unf = 1;
            m_valid = rd_ok;
            if (rd_ok) begin
                m_data = q.pop_front();
                m_rd++;
            end
            if (wr_ok) begin
                q.push_back(d);
                m_wr++;
            end
            m_fd = rd_ok && (m_rd == TOTAL);
            if (m_fd) begin
                m_wr = 0;
                m_rd = 0;
            end
        end
    endtask

    task automatic cycle(input bit r, input bit we, input bit re,
                         input logic [PW-1:0] d);
        rst      = r;
        wr_valid = we;
        rd_en    = re;
        wr_data  = d;
        @(posedge clk);
        #1;
        model_step(r, we, re, d);
    endtask

    // ---------------- per-cycle compare ----------------
    bit cmp_en = 0;

    always @(negedge clk) begin
        if (cmp_en) begin
            check("wr_ready",         PW'(wr_ready),         PW'(m_wr_ready()));
            check("out_valid",        PW'(out_valid),        PW'(m_valid));
            check("out_data",         out_data,              m_data);
            check("fifo_empty",       PW'(fifo_empty),       PW'(m_empty()));
            check("fifo_batch_ready", PW'(fifo_batch_ready), PW'(m_batch()));
            check("fifo_last_batch",  PW'(fifo_last_batch),  PW'(m_last()));
            check("frame_done",       PW'(frame_done),       PW'(m_fd));
            check("overflow_err",     PW'(overflow_err),     PW'(m_ovf));
            check("underflow_err",    PW'(underflow_err),    PW'(m_unf));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int  rd_idx;
        int  frames;
        int  budget;
        bit  we;
        bit  re;
        logic [PW-1:0] d;

        rst = 1'b1; wr_valid = 1'b0; rd_en = 1'b0; wr_data = '0;
        cycle(1, 0, 0, '0);
        cycle(1, 0, 0, '0);
        cmp_en = 1;

        // Reset state.
        check("rst_empty",     PW'(fifo_empty),       PW'(1));
        check("rst_wr_ready",  PW'(wr_ready),         PW'(1));
        check("rst_out_valid", PW'(out_valid),        PW'(0));
        check("rst_out_data",  out_data,              '0);
        check("rst_batch",     PW'(fifo_batch_ready), PW'(0));
        check("rst_last",      PW'(fifo_last_batch),  PW'(0));
        check("rst_ovf",       PW'(overflow_err),     PW'(0));
        check("rst_unf",       PW'(underflow_err),    PW'(0));

        // Batch threshold.
        for (int i = 0; i < 27; i++) cycle(0, 1, 0, pix(i));
        check("batch_27", PW'(fifo_batch_ready), PW'(0));
        cycle(0, 1, 0, pix(27));
        check("batch_28", PW'(fifo_batch_ready), PW'(1));
        cycle(0, 0, 1, '0);
        check("rd0_valid", PW'(out_valid),        PW'(1));
        check("rd0_data",  out_data,              pix(0));
        check("batch_27b", PW'(fifo_batch_ready), PW'(0));

        // Read latency with pixel 5 at the head.
        for (int i = 1; i < 5; i++) cycle(0, 0, 1, '0);
        cycle(0, 0, 0, '0);
        check("idle_valid", PW'(out_valid), PW'(0));
        cycle(0, 0, 1, '0);
        d = out_data;
        check("lat_valid", PW'(out_valid), PW'(1));
        check("lat_ch0",   PW'(d[7:0]),     PW'(8'd5));
        check("lat_ch15",  PW'(d[127:120]), PW'(8'd80));
        rd_idx = 6;

        // Randomized stream: finish this frame, then a full second frame.
        frames = 0;
        budget = 0;
        while (frames < 2 && budget < 20000) begin
            we = m_wr_ready() && ($urandom_range(3) != 0);
            re = m_batch() && ($urandom_range(2) != 0);
            d  = we ? pix(m_wr) : {4{$urandom}};
            cycle(0, we, re, d);
            budget++;
            if (out_valid) begin
                check("stream_order", out_data, pix(rd_idx));
                check("stream_fd",    PW'(frame_done), PW'(rd_idx == TOTAL - 1));
                if (rd_idx == TOTAL - 1) begin
                    rd_idx = 0;
                    frames++;
                end else begin
                    rd_idx++;
                end
            end
        end
        check("frames_done", PW'(frames), PW'(2));

        // Full / overflow.
        cycle(1, 0, 0, '0);
        for (int i = 0; i < DEPTH; i++) cycle(0, 1, 0, pix(i));
        check("full_wr_ready", PW'(wr_ready), PW'(0));
        cycle(0, 1, 0, pix(99));
        check("ovf_set", PW'(overflow_err), PW'(1));
        cycle(0, 1, 1, pix(100));
        check("full_rd_data",  out_data,       pix(0));
        check("full_rd_ready", PW'(wr_ready),  PW'(1));
        cycle(0, 0, 1, '0);
        check("full_rd1_data", out_data, pix(1));

        // Underflow and mid-frame reset.
        cycle(1, 0, 0, '0);
        cycle(0, 0, 1, '0);
        check("unf_valid", PW'(out_valid),     PW'(0));
        check("unf_set",   PW'(underflow_err), PW'(1));
        for (int i = 0; i < 40; i++) cycle(0, 1, 0, pix(i + 50));
        check("pre_rst_empty", PW'(fifo_empty), PW'(0));
        cycle(1, 0, 0, '0);
        check("mid_rst_empty", PW'(fifo_empty),    PW'(1));
        check("mid_rst_ovf",   PW'(overflow_err),  PW'(0));
        check("mid_rst_unf",   PW'(underflow_err), PW'(0));
        cycle(0, 1, 0, pix(7));
        cycle(0, 0, 1, '0);
        check("fresh_valid", PW'(out_valid), PW'(1));
        check("fresh_data",  out_data,       pix(7));
        cycle(0, 0, 0, '0);
        cycle(0, 0, 0, '0);

        cmp_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
